// File: rtl/router_reg.sv
// -----------------------------------------------------------------------------
// router_reg : datapath register stage of the 1x3 router
//
// Works next to the router control FSM. The FSM tells this block which state
// it is in through one-hot strobes; this block latches the packet header,
// forwards header/payload/parity bytes to the output FIFOs on dout, parks the
// byte that arrives while the selected FIFO is full, and checks packet parity.
//
// Ports
//   clk            clock, all registers update on the rising edge
//   resetn         synchronous, active-low reset
//   pkt_valid      source byte valid (high for header+payload, low on parity)
//   data_in        source byte
//   fifo_full      selected output FIFO is full
//   detect_add     FSM in DECODE_ADDRESS
//   lfd_state      FSM in LOAD_FIRST_DATA
//   ld_state       FSM in LOAD_DATA
//   laf_state      FSM in LOAD_AFTER_FULL
//   full_state     FSM in FIFO_FULL_STATE
//   rst_int_reg    FSM in CHECK_PARITY_ERROR
//   dout           byte presented to the FIFO write port (one clock behind source)
//   parity_done    packet parity byte has been captured
//   low_pkt_valid  pkt_valid dropped while loading data (parity byte seen)
//   err            computed parity differs from the received parity byte
// -----------------------------------------------------------------------------
module router_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             pkt_valid,
   input  logic [WIDTH-1:0] data_in,
   input  logic             fifo_full,
   input  logic             detect_add,
   input  logic             lfd_state,
   input  logic             ld_state,
   input  logic             laf_state,
   input  logic             full_state,
   input  logic             rst_int_reg,
   output logic [WIDTH-1:0] dout,
   output logic             parity_done,
   output logic             low_pkt_valid,
   output logic             err
);

   logic [WIDTH-1:0] header_reg;
   logic [WIDTH-1:0] hold_reg;
   logic [WIDTH-1:0] dout_reg;
   logic [WIDTH-1:0] internal_parity_reg;
   logic [WIDTH-1:0] packet_parity_reg;
   logic             parity_done_reg;
   logic             low_pkt_valid_reg;
   logic             err_reg;

   // Address 3 does not exist on a 1x3 router; such a header is ignored so
   // the previously latched header stays in place.
   logic header_ok;
   assign header_ok = detect_add && pkt_valid && (data_in[1:0] != 2'b11);

   // Header latch and the byte path towards the FIFOs. The byte that arrives
   // while the FIFO is full is parked in hold_reg and replayed from
   // LOAD_AFTER_FULL, so no source byte is lost.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         header_reg <= '0;
         hold_reg   <= '0;
         dout_reg   <= '0;
      end else begin
         if (header_ok)
            header_reg <= data_in;

         if (lfd_state)
            dout_reg <= header_reg;
         else if (ld_state && !fifo_full)
            dout_reg <= data_in;
         else if (ld_state && fifo_full)
            hold_reg <= data_in;
         else if (laf_state)
            dout_reg <= hold_reg;
      end
   end

   // Running XOR of header and payload, plus the received parity byte.
   // A payload byte diverted into hold_reg is still accumulated here because
   // it is accepted from the source in that cycle; full_state only guards
   // against counting anything while the FSM is stalled.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         internal_parity_reg <= '0;
         packet_parity_reg   <= '0;
      end else begin
         if (detect_add)
            internal_parity_reg <= '0;
         else if (lfd_state)
            internal_parity_reg <= internal_parity_reg ^ header_reg;
         else if (ld_state && pkt_valid && !full_state)
            internal_parity_reg <= internal_parity_reg ^ data_in;

         if (detect_add)
            packet_parity_reg <= '0;
         else if (ld_state && !pkt_valid)
            packet_parity_reg <= data_in;
      end
   end

   // Status flags back to the FSM and the host.
   // parity_done rises either when the parity byte is written straight through,
   // or, if it was parked because the FIFO was full, on the LOAD_AFTER_FULL
   // cycle that replays it. err is evaluated only once parity_done is up, so
   // both parity registers are settled when it is computed.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         parity_done_reg   <= 1'b0;
         low_pkt_valid_reg <= 1'b0;
         err_reg           <= 1'b0;
      end else begin
         if (ld_state && !pkt_valid)
            low_pkt_valid_reg <= 1'b1;
         else if (rst_int_reg)
            low_pkt_valid_reg <= 1'b0;

         if (detect_add)
            parity_done_reg <= 1'b0;
         else if ((ld_state && !fifo_full && !pkt_valid) ||
                  (laf_state && low_pkt_valid_reg && !parity_done_reg))
            parity_done_reg <= 1'b1;

         if (detect_add)
            err_reg <= 1'b0;
         else if (parity_done_reg)
            err_reg <= (internal_parity_reg != packet_parity_reg);
      end
   end

   assign dout          = dout_reg;
   assign parity_done   = parity_done_reg;
   assign low_pkt_valid = low_pkt_valid_reg;
   assign err           = err_reg;

endmodule

// File: tb/tb_router_reg.sv
// -----------------------------------------------------------------------------
// tb_router_reg : self-checking bench for router_reg
//
// Drives legal FSM strobe sequences packet by packet. The reference model is
// packet level: the expected FIFO byte stream is header, payload, parity
// byte in order, and the expected err is whether the XOR of the effective
// header and payload differs from the received parity byte.
// -----------------------------------------------------------------------------
module tb_router_reg;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             resetn;
   logic             pkt_valid;
   logic [WIDTH-1:0] data_in;
   logic             fifo_full;
   logic             detect_add;
   logic             lfd_state;
   logic             ld_state;
   logic             laf_state;
   logic             full_state;
   logic             rst_int_reg;
   logic [WIDTH-1:0] dout;
   logic             parity_done;
   logic             low_pkt_valid;
   logic             err;

   int total = 0;
   int bad   = 0;

   // Model state
   logic [7:0]  hdr_model;    // header the DUT should currently hold
   logic [7:0]  exp_dout;     // last byte the DUT should have presented
   logic [7:0]  pay [0:15];
   int          pay_len;
   logic [15:0] full_mask;    // payload byte i arrives while FIFO full
   logic [7:0]  trailer;
   logic        trailer_full;

   router_reg #(.WIDTH(WIDTH)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .rst_int_reg   (rst_int_reg),
      .dout          (dout),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .err           (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_strobes();
      detect_add  = 1'b0;
      lfd_state   = 1'b0;
      ld_state    = 1'b0;
      laf_state   = 1'b0;
      full_state  = 1'b0;
      rst_int_reg = 1'b0;
      fifo_full   = 1'b0;
   endtask

   // FIFO_FULL_STATE for n cycles, then one LOAD_AFTER_FULL cycle.
   task automatic full_then_laf(input int n, input logic pd_exp);
      for (int k = 0; k < n; k++) begin
         clear_strobes();
         full_state = 1'b1;
         fifo_full  = 1'b1;
         data_in    = 8'($urandom);
         tick();
         check("full_dout_hold", dout, exp_dout);
         check("full_pd", parity_done, pd_exp);
      end
      clear_strobes();
      laf_state = 1'b1;
      data_in   = 8'($urandom);
      tick();
      clear_strobes();
   endtask

   // Sends header + pay[0..pay_len-1] + trailer. With abort set, stops right
   // after the second payload byte so the caller can reset mid-packet.
   task automatic send_packet(input logic [7:0] hdr, input bit abort);
      logic [7:0] hdr_eff;
      logic [7:0] par;
      logic       exp_err;
      hdr_eff = (hdr[1:0] != 2'b11) ? hdr : hdr_model;
      par = hdr_eff;
      for (int i = 0; i < pay_len; i++) par = par ^ pay[i];
      exp_err = (par != trailer);

      // DECODE_ADDRESS
      clear_strobes();
      detect_add = 1'b1;
      pkt_valid  = 1'b1;
      data_in    = hdr;
      tick();
      hdr_model = hdr_eff;
      check("detect_dout_hold", dout, exp_dout);
      check("detect_pd_clr", parity_done, 0);
      check("detect_err_clr", err, 0);

      // LOAD_FIRST_DATA
      clear_strobes();
      lfd_state = 1'b1;
      data_in   = 8'($urandom);
      tick();
      exp_dout = hdr_eff;
      check("lfd_dout", dout, exp_dout);

      // LOAD_DATA payload
      for (int i = 0; i < pay_len; i++) begin
         clear_strobes();
         ld_state  = 1'b1;
         pkt_valid = 1'b1;
         data_in   = pay[i];
         fifo_full = full_mask[i];
         tick();
         if (!full_mask[i]) begin
            exp_dout = pay[i];
            check("ld_dout", dout, exp_dout);
         end else begin
            check("ld_full_dout_hold", dout, exp_dout);
            full_then_laf($urandom_range(1, 3), 1'b0);
            exp_dout = pay[i];
            check("laf_dout", dout, exp_dout);
         end
         check("ld_lpv", low_pkt_valid, 0);
         if (abort && i == 1) begin
            clear_strobes();
            return;
         end
      end

      // Parity byte
      clear_strobes();
      ld_state  = 1'b1;
      pkt_valid = 1'b0;
      data_in   = trailer;
      fifo_full = trailer_full;
      tick();
      check("par_lpv_set", low_pkt_valid, 1);
      if (!trailer_full) begin
         exp_dout = trailer;
         check("par_dout", dout, exp_dout);
         check("par_pd_set", parity_done, 1);
      end else begin
         check("par_full_dout_hold", dout, exp_dout);
         check("par_full_pd_low", parity_done, 0);
         full_then_laf($urandom_range(1, 3), 1'b0);
         exp_dout = trailer;
         check("par_laf_dout", dout, exp_dout);
         check("par_laf_pd_set", parity_done, 1);
      end
      check("pd_rise_err_low", err, 0);

      // LOAD_PARITY: err becomes valid
      clear_strobes();
      pkt_valid = 1'b0;
      data_in   = 8'($urandom);
      tick();
      check("err_value", err, exp_err);
      check("pd_stays", parity_done, 1);

      // CHECK_PARITY_ERROR
      rst_int_reg = 1'b1;
      tick();
      check("cpe_lpv_clr", low_pkt_valid, 0);
      check("cpe_err_hold", err, exp_err);
      check("cpe_pd_hold", parity_done, 1);
      clear_strobes();
      $display("pkt hdr=%02h eff=%02h len=%0d trailer=%02h tfull=%0d err_exp=%0d",
               hdr, hdr_eff, pay_len, trailer, trailer_full, exp_err);
   endtask

   task automatic set_pay3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      pay[0] = a; pay[1] = b; pay[2] = c;
      pay_len = 3;
   endtask

   initial begin
      clear_strobes();
      resetn    = 1'b0;
      pkt_valid = 1'b1;
      data_in   = 8'hFF;
      detect_add = 1'b1;     // reset must also beat a header capture
      ld_state   = 1'b1;
      hdr_model = 8'h00;
      exp_dout  = 8'h00;

      // Reset
      tick();
      tick();
      check("rst_dout", dout, 0);
      check("rst_pd", parity_done, 0);
      check("rst_lpv", low_pkt_valid, 0);
      check("rst_err", err, 0);
      clear_strobes();
      resetn = 1'b1;
      tick();

      // Good packet to port 1
      set_pay3(8'h11, 8'h22, 8'h33);
      full_mask = '0; trailer = 8'h0D; trailer_full = 1'b0;
      send_packet(8'h0D, 1'b0);

      // Bad parity
      trailer = 8'h00;
      send_packet(8'h0D, 1'b0);

      // FIFO full mid-payload on A5, three full cycles handled by random n,
      // parity must still include A5
      set_pay3(8'h11, 8'hA5, 8'h33);
      full_mask = 16'h0002; trailer = 8'h0D ^ 8'h11 ^ 8'hA5 ^ 8'h33; trailer_full = 1'b0;
      send_packet(8'h0D, 1'b0);

      // Parity byte arrives while full
      set_pay3(8'h11, 8'h22, 8'h33);
      full_mask = '0; trailer = 8'h5A; trailer_full = 1'b1;
      send_packet(8'h0D, 1'b0);

      // Invalid address 3: previous header 0D is used
      trailer = 8'h0D; trailer_full = 1'b0;
      send_packet(8'h07, 1'b0);

      // Reset in mid-packet discards everything, header included
      send_packet(8'h26, 1'b1);
      resetn = 1'b0;
      tick();
      check("midrst_dout", dout, 0);
      check("midrst_pd", parity_done, 0);
      check("midrst_lpv", low_pkt_valid, 0);
      check("midrst_err", err, 0);
      resetn = 1'b1;
      hdr_model = 8'h00;
      exp_dout  = 8'h00;
      trailer = 8'h00 ^ 8'h11 ^ 8'h22 ^ 8'h33;
      send_packet(8'hFB, 1'b0);   // address 3 after reset: header must be 0

      // Randomized packets
      for (int p = 0; p < 40; p++) begin
         logic [7:0] h;
         logic [7:0] x;
         h = 8'($urandom);
         pay_len = $urandom_range(1, 8);
         full_mask = '0;
         for (int i = 0; i < pay_len; i++) begin
            pay[i] = 8'($urandom);
            full_mask[i] = ($urandom_range(0, 3) == 0);
         end
         x = (h[1:0] != 2'b11) ? h : hdr_model;
         for (int i = 0; i < pay_len; i++) x = x ^ pay[i];
         trailer = ($urandom_range(0, 1) == 0) ? x : (x ^ 8'($urandom_range(1, 255)));
         trailer_full = ($urandom_range(0, 3) == 0);
         send_packet(h, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router.
- Sits beside the router control FSM and consumes its state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Latches the header, forwards header/payload/parity bytes to the output FIFOs on dout, and holds the byte that arrives while the FIFO is full.
- Computes running parity and returns parity_done / low_pkt_valid to the FSM, plus err to the host.

Parameters:
- WIDTH, 8, byte width of data_in/dout/parity registers (header address field is always bits [1:0]).

Ports:
- clk  in  1  clock, all registers on rising edge
- resetn  in  1  synchronous, active-low reset
- pkt_valid  in  1  source byte valid; high for header+payload, low on the parity byte
- data_in  in  WIDTH  source byte
- fifo_full  in  1  selected output FIFO full
- detect_add  in  1  FSM in DECODE_ADDRESS
- lfd_state  in  1  FSM in LOAD_FIRST_DATA
- ld_state  in  1  FSM in LOAD_DATA
- laf_state  in  1  FSM in LOAD_AFTER_FULL
- full_state  in  1  FSM in FIFO_FULL_STATE
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR
- dout  out  WIDTH  byte to FIFO write port
- parity_done  out  1  packet parity byte has been captured
- low_pkt_valid  out  1  pkt_valid fell while in LOAD_DATA (parity byte seen)
- err  out  1  parity mismatch for the last packet

Behaviour:
- Reset (resetn=0 at an edge): dout, header, hold, internal_parity, packet_parity = 0; parity_done, low_pkt_valid, err = 0. Reset mid-packet discards everything; no partial state survives.
- Header capture: detect_add && pkt_valid && data_in[1:0]!=2'b11 -> header <= data_in. Address 3 is ignored and header holds.
- dout update, priority order, else hold:
  - lfd_state -> header.
  - ld_state && !fifo_full -> data_in.
  - ld_state && fifo_full -> hold <= data_in, dout unchanged.
  - laf_state -> hold.
- dout therefore lags its source by exactly one clock. The FSM's write_enb in the following state writes it.
- Internal parity (XOR accumulator):
  - detect_add -> 0.
  - lfd_state -> ^= header.
  - ld_state && pkt_valid && !full_state -> ^= data_in. This includes the byte diverted to hold.
  - The parity byte (pkt_valid=0) is never accumulated.
- Packet parity:
  - ld_state && !pkt_valid -> packet_parity <= data_in.
  - detect_add -> 0.
- low_pkt_valid:
  - set when ld_state && !pkt_valid.
  - cleared when rst_int_reg; reset 0.
  - Set wins over clear if both occur (cannot happen in a legal FSM sequence).
- parity_done:
  - set when (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_pkt_valid && !parity_done).
  - cleared when detect_add.
  - Stays set through LOAD_PARITY / CHECK_PARITY_ERROR.
- err:
  - When parity_done=1, err <= (internal_parity != packet_parity) each cycle.
  - detect_add clears it to 0.
  - First valid the cycle after parity_done rises; holds until the next DECODE_ADDRESS.
- Simultaneous events:
  - detect_add clear has priority over all set terms.
  - fifo_full dropping in the same cycle as ld_state uses the sampled value only.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset: hold resetn=0 for 2 clocks with data_in=8'hFF, pkt_valid=1 -> dout=0, parity_done=0, low_pkt_valid=0, err=0.
- Good packet to port 1:
  - Sequence: detect_add with data_in=8'h0D (len 3, addr 1), lfd, then ld with bytes 8'h11, 8'h22, 8'h33 (pkt_valid=1), then parity byte 8'h0D^11^22^33=8'h0D (pkt_valid=0).
  - dout sequence 0D,11,22,33,0D one clock after each source byte; parity_done=1 the cycle after the parity byte; err stays 0.
- Bad parity: same packet with parity byte 8'h00 -> parity_done=1, then err=1 next clock; err returns to 0 on the next detect_add.
- FIFO full mid-payload:
  - In ld_state, assert fifo_full while data_in=8'hA5 -> dout keeps its previous byte and hold=8'hA5.
  - full_state for 3 clocks, then laf_state -> dout=8'hA5.
  - Parity still includes A5, so a correct trailer gives err=0.
- Parity byte arrives while full:
  - ld_state, pkt_valid=0, fifo_full=1, data_in=8'h5A -> low_pkt_valid=1, parity_done stays 0.
  - Then laf_state -> parity_done=1; rst_int_reg clears low_pkt_valid.
- Invalid address 3: detect_add, pkt_valid=1, data_in=8'h07 -> header unchanged; a following lfd_state outputs the previous header value.
